sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO, next generation of the team's sync FIFO.
//  Adds almost-full/almost-empty thresholds, an occupancy count, a read-valid strobe,
//  registered error pulses and defined simultaneous read/write at full and empty.
//  Sits between a producer and consumer in one clock domain; drop-in for the older FIFO.
// PARAMETERS
//  WIDTH      8   data word width, bits
//  DEPTH      16  entries; power of two, >=2
//  PTR_ADDR   4   log2(DEPTH); must equal clog2(DEPTH)
//  AF_THRESH  14  almost_full_o when count_o >= AF_THRESH; range 1..DEPTH
//  AE_THRESH  2   almost_empty_o when count_o <= AE_THRESH; range 0..DEPTH-1
// PORTS
//  clk_i          in   1           clock, rising edge
//  rst_i          in   1           synchronous reset, active-high
//  wr_en_i        in   1           write request
//  wdata_i        in   WIDTH       write data
//  full_o         out  1           FIFO holds DEPTH words
//  almost_full_o  out  1           count_o >= AF_THRESH
//  wr_error_o     out  1           one-cycle pulse: previous-cycle write rejected
//  rd_en_i        in   1           read request
//  rdata_o        out  WIDTH       read data
//  rvalid_o       out  1           rdata_o valid
//  empty_o        out  1           FIFO holds 0 words
//  almost_empty_o out  1           count_o <= AE_THRESH
//  rd_error_o     out  1           one-cycle pulse: previous-cycle read rejected
//  count_o        out  PTR_ADDR+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset: clk_i posedge with rst_i=1 sets pointers 0. Next cycle: count_o=0, empty_o=1,
//    almost_empty_o=1, full_o=0, almost_full_o=(AF_THRESH==0 never)=0, wr/rd_error_o=0,
//    rvalid_o=0, rdata_o=0. Memory is not cleared.
//  - Reset mid-operation: all stored words are discarded. rst_i overrides wr_en_i/rd_en_i that cycle.
//  - Pointers are PTR_ADDR+1 bits; MSB is the wrap bit. empty = ptrs equal.
//    full = MSBs differ, low bits equal. count_o = wr_ptr - rd_ptr, modulo 2^(PTR_ADDR+1).
//  - All flags and count_o are decoded from registered pointers only; no input-to-output
//    combinational path. Flags reflect an accepted op the cycle after it.
//  - rd_acc = rd_en_i & ~empty_o.
//  - wr_acc = wr_en_i & (~full_o | rd_en_i).
//    At full with both requests, both are accepted; count is unchanged; no error.
//    At empty with both requests, the write is accepted and the read is rejected (rd_error_o).
//  - wr_error_o <= wr_en_i & ~wr_acc. rd_error_o <= rd_en_i & ~rd_acc.
//    Each is a registered pulse per rejected request and is not sticky.
//    Rejected ops do not move pointers or corrupt data.
//  - Standard read: on rd_acc, rdata_o <= mem[rd_ptr] and rvalid_o <= 1 (latency 1).
//    Otherwise rvalid_o <= 0 and rdata_o holds its value.
//  - Write: on wr_acc, mem[wr_ptr] <= wdata_i.
//  - Pointer wrap past DEPTH-1 is seamless.
//  - Elaboration check fails on: non-power-of-two DEPTH, PTR_ADDR mismatch, or an
//    out-of-range threshold.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN: first-word-fall-through.
//   - Defined: rdata_o = mem[rd_ptr] (combinational from registered state, 0 when empty).
//     rvalid_o = ~empty_o. rd_en_i pops the displayed word. Read latency 0.
//   - Undefined: standard registered read as above.
//   Flags, count_o and error semantics are identical in both modes.
// STRUCTURE
//  - Shared package/include sync_fifo_pkg: clog2 function, default WIDTH/DEPTH constants,
//    threshold range-check macro.
//  - One sub-module, sync_fifo_mem: DEPTH x WIDTH array, 1 synchronous write port,
//    1 asynchronous read port, no reset.
//  - Pointers, flags, errors and read register live in sync_fifo_flags.
// TESTING (WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
//  1. Reset, then write 0x01..0x10 on 16 consecutive cycles.
//     -> almost_empty_o drops after the 3rd write; almost_full_o rises after the 14th;
//        full_o=1 and count_o=16 after the 16th. A 17th write gives wr_error_o=1 for
//        exactly one cycle, and count_o stays 16.
//  2. From full, 16 reads.
//     -> rdata_o=0x01..0x10 in order, each with rvalid_o=1 one cycle after rd_en_i;
//        empty_o=1 after the last. An extra read gives one rd_error_o pulse.
//  3. Write 9, then read 13.
//     -> 9 valid words in order, then exactly 4 rd_error_o pulses; count_o=0.
//  4. Simultaneous ops.
//     -> At full, wr_en_i=rd_en_i=1 gives count_o=16, no errors, rdata_o=oldest word.
//     -> At empty, both=1 gives count_o=1 and one rd_error_o pulse.
//  5. Wrap: 40 cycles with alternating bursts of 5 writes and 5 reads, ramp data.
//     -> Output order equals input order across pointer wrap; count_o never exceeds 16.
//  6. With count_o=7, assert rst_i for 1 cycle with wr_en_i=1.
//     -> Next cycle count_o=0, empty_o=1, rvalid_o=0, errors 0.
//     -> With SYNC_FIFO_FWFT_EN: write 0xA5 gives rdata_o=0xA5 and rvalid_o=1 in the cycle
//        empty_o falls.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a. Provides clog2, default sizes and the threshold range-check macro.

`ifndef SYNC_FIFO_PKG_SV
`define SYNC_FIFO_PKG_SV

// True when both occupancy thresholds are legal for a FIFO of depth d.
`define SYNC_FIFO_THRESH_OK(af, ae, d) \
  (((af) >= 1) && ((af) <= (d)) && ((ae) >= 0) && ((ae) <= ((d) - 1)))

package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Smallest r such that 2**r >= n (n >= 1).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags.
// Latency: n/a (wires only).
// Backpressure: full_o/empty_o plus error pulses; see sync_fifo_flags.
// Ports (slave = FIFO side):
//   in : wr_en_i, wdata_i, rd_en_i
//   out: full_o, almost_full_o, wr_error_o, rdata_o, rvalid_o, empty_o,
//        almost_empty_o, rd_error_o, count_o

interface sync_fifo_flags_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PTR_ADDR = clog2(DEF_DEPTH)
);
  logic                wr_en_i;
  logic [WIDTH-1:0]    wdata_i;
  logic                full_o;
  logic                almost_full_o;
  logic                wr_error_o;
  logic                rd_en_i;
  logic [WIDTH-1:0]    rdata_o;
  logic                rvalid_o;
  logic                empty_o;
  logic                almost_empty_o;
  logic                rd_error_o;
  logic [PTR_ADDR:0]   count_o;

  // Producer/consumer side.
  modport master (
    output wr_en_i, wdata_i, rd_en_i,
    input  full_o, almost_full_o, wr_error_o, rdata_o, rvalid_o,
           empty_o, almost_empty_o, rd_error_o, count_o
  );

  // FIFO side.
  modport slave (
    input  wr_en_i, wdata_i, rd_en_i,
    output full_o, almost_full_o, wr_error_o, rdata_o, rvalid_o,
           empty_o, almost_empty_o, rd_error_o, count_o
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
// Latency: write visible on the read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller decides when a write is allowed.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.

module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PTR_ADDR = clog2(DEF_DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [PTR_ADDR-1:0] waddr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic [PTR_ADDR-1:0] raddr_i,
  output logic [WIDTH-1:0]    rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost-full/empty flags, read-valid strobe and error pulses.
// Latency: registered read 1 cycle; SYNC_FIFO_FWFT_EN gives first-word-fall-through (0 cycles).
// Backpressure: writes at full are rejected unless a read pops the same cycle; reads at empty
//   are rejected; each rejection raises a one-cycle wr_error_o/rd_error_o the next cycle.
// Ports: clk_i, rst_i (sync, active-high), fifo_if (sync_fifo_flags_if.slave).
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.

module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_ADDR  = clog2(DEF_DEPTH),
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sync_fifo_flags_if.slave fifo_if
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (PTR_ADDR != clog2(DEPTH)) begin : g_bad_ptr
    $error("sync_fifo_flags: PTR_ADDR must equal clog2(DEPTH)");
  end
  if (!(`SYNC_FIFO_THRESH_OK(AF_THRESH, AE_THRESH, DEPTH))) begin : g_bad_thresh
    $error("sync_fifo_flags: AF_THRESH/AE_THRESH out of range");
  end

  localparam logic [PTR_ADDR:0] AF_LVL = (PTR_ADDR + 1)'(AF_THRESH);
  localparam logic [PTR_ADDR:0] AE_LVL = (PTR_ADDR + 1)'(AE_THRESH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_ADDR:0] wr_ptr;
  logic [PTR_ADDR:0] rd_ptr;
  logic [PTR_ADDR:0] count;
  logic              empty;
  logic              full;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_err_q;
  logic              rd_err_q;
  logic [WIDTH-1:0]  mem_rdata;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_ADDR] != rd_ptr[PTR_ADDR]) &&
                  (wr_ptr[PTR_ADDR-1:0] == rd_ptr[PTR_ADDR-1:0]);
  assign count  = wr_ptr - rd_ptr;

  // A write at full is still taken when a read frees the slot in the same cycle.
  assign rd_acc = fifo_if.rd_en_i & ~empty;
  assign wr_acc = fifo_if.wr_en_i & (~full | fifo_if.rd_en_i);

  sync_fifo_mem #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .PTR_ADDR (PTR_ADDR)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc & ~rst_i),
    .waddr_i (wr_ptr[PTR_ADDR-1:0]),
    .wdata_i (fifo_if.wdata_i),
    .raddr_i (rd_ptr[PTR_ADDR-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      wr_err_q <= fifo_if.wr_en_i & ~wr_acc;
      rd_err_q <= fifo_if.rd_en_i & ~rd_acc;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always on display; rd_en_i just advances past it.
  assign fifo_if.rdata_o  = empty ? '0 : mem_rdata;
  assign fifo_if.rvalid_o = ~empty;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign fifo_if.rdata_o  = rdata_q;
  assign fifo_if.rvalid_o = rvalid_q;
`endif

  assign fifo_if.full_o         = full;
  assign fifo_if.empty_o        = empty;
  assign fifo_if.almost_full_o  = (count >= AF_LVL);
  assign fifo_if.almost_empty_o = (count <= AE_LVL);
  assign fifo_if.count_o        = count;
  assign fifo_if.wr_error_o     = wr_err_q;
  assign fifo_if.rd_error_o     = rd_err_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised and directed stimulus against a queue-based reference of the FIFO.
// Read data is scoreboarded: expected words queued at acceptance, a monitor compares on rvalid_o.
// Flags, count and error pulses are compared every cycle against the reference occupancy.

module tb_sync_fifo_flags;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  sync_fifo_flags_if #(.WIDTH(8), .PTR_ADDR(4)) bus ();

  sync_fifo_flags #(
    .WIDTH     (8),
    .DEPTH     (DEPTH),
    .PTR_ADDR  (4),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .fifo_if (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];  // words held by the FIFO, oldest first
  logic [7:0] exp_rd[$];   // words the DUT owes on rvalid_o

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_flags(input bit exp_we, input bit exp_re);
    int n;
    n = model_q.size();
    chk("count",        32'(bus.count_o),        32'(n));
    chk("empty",        32'(bus.empty_o),        32'(n == 0));
    chk("full",         32'(bus.full_o),         32'(n == DEPTH));
    chk("almost_full",  32'(bus.almost_full_o),  32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty_o), 32'(n <= AE));
    chk("wr_error",     32'(bus.wr_error_o),     32'(exp_we));
    chk("rd_error",     32'(bus.rd_error_o),     32'(exp_re));
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_rvalid",  32'(bus.rvalid_o),       32'(n > 0));
    if (n > 0) chk("fwft_rdata", 32'(bus.rdata_o), 32'(model_q[0]));
`endif
  endtask

  // One clock of stimulus; the reference decides acceptance from occupancy alone.
  task automatic cycle(input bit wr, input logic [7:0] wd, input bit rd);
    int n;
    bit rd_ok;
    bit wr_ok;
    logic [7:0] head;
    n     = model_q.size();
    rd_ok = rd && (n > 0);
    wr_ok = wr && ((n < DEPTH) || rd);
    head  = (n > 0) ? model_q[0] : 8'h00;
    rst_i       = 1'b0;
    bus.wr_en_i = wr;
    bus.wdata_i = wd;
    bus.rd_en_i = rd;
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(wd);
    @(posedge clk_i);
`ifndef SYNC_FIFO_FWFT_EN
    if (rd_ok) exp_rd.push_back(head);
`endif
    #1;
    check_flags(wr && !wr_ok, rd && !rd_ok);
  endtask

  task automatic do_reset(input bit wr);
    rst_i       = 1'b1;
    bus.wr_en_i = wr;
    bus.wdata_i = 8'hEE;
    bus.rd_en_i = 1'b0;
    model_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_flags(1'b0, 1'b0);
    chk("reset_rvalid", 32'(bus.rvalid_o), 32'(0));
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset_rdata",  32'(bus.rdata_o),  32'(0));
`endif
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the DUT's update edge.
  initial begin
    forever begin
      @(negedge clk_i);
`ifndef SYNC_FIFO_FWFT_EN
      if (rst_i === 1'b0 && bus.rvalid_o === 1'b1) begin
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rvalid_unexpected: got rdata %0h expected no read", bus.rdata_o);
        end else begin
          chk("rdata", 32'(bus.rdata_o), 32'(exp_rd.pop_front()));
        end
      end else if (rst_i === 1'b0 && exp_rd.size() != 0) begin
        chk("rvalid_missing", 32'(bus.rvalid_o), 32'(1));
        void'(exp_rd.pop_front());
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ramp;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.wdata_i = 8'h00;

    // 1. fill, then one rejected write and an idle cycle to see the pulse clear
    do_reset(1'b0);
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // 2. drain, plus one rejected read
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // 3. write 9, read 13
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 13; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // 4. simultaneous ops at full and at empty
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    cycle(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // 5. wrap with bursts of 5 writes / 5 reads
    ramp = 8'h80;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 5; i++) begin
        cycle(1'b1, ramp, 1'b0);
        ramp = ramp + 8'h01;
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    end

    // 6. reset from count 7 with a write pending, then one fresh word
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    do_reset(1'b1);
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    @(negedge clk_i);
    chk("scoreboard_drained", 32'(exp_rd.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
